// File: rtl/cp0_count_timer.sv
// ---------------------------------------------------------------------------
// cp0_count_timer
//
// Holds the CP0 Count register (reg 9, sel 0) and raises the CP0 timer
// interrupt when Count equals the registered Compare value.
//
// Count advances once every two core cycles using a 1-bit phase divider.
// Both Count and the phase freeze while Cause.DC (count_dis) is set.
// timer_int is sticky. Only a Compare write or reset clears it.
//
// Ports:
//   clk            core clock
//   rst            synchronous reset, active-high
//   mtc0_we        qualified MTC0 write strobe
//   cp0_addr       {rd[4:0], sel[2:0]} of the MTC0/MFC0 target
//   mtc0_data      MTC0 write data
//   compare_data   registered value of the Compare register
//   count_dis      Cause.DC, freezes Count and tick phase
//   cp0_Count_data Count register value (to the MFC0 mux)
//   timer_int      sticky timer-interrupt pending (Cause.TI / IP7)
//   count_tick     high in cycles where Count increments
// ---------------------------------------------------------------------------
module cp0_count_timer #(
  parameter logic [31:0] COUNT_INI    = 32'h0000_0000,
  parameter logic [7:0]  ADDR_COUNT   = 8'b01001_000,
  parameter logic [7:0]  ADDR_COMPARE = 8'b01011_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0_we,
  input  logic [7:0]  cp0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [31:0] compare_data,
  input  logic        count_dis,
  output logic [31:0] cp0_Count_data,
  output logic        timer_int,
  output logic        count_tick
);

  localparam int DATA_W = 32;

  // Count arithmetic is plain modulo-2^32. The wrap raises no flag.
  function automatic logic [DATA_W-1:0] count_inc(input logic [DATA_W-1:0] v);
    count_inc = v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  logic [DATA_W-1:0] count_p0;
  logic              phase_p0;
  logic              timer_int_p0;

  logic              wr_count;
  logic              wr_compare;
  logic              tick;
  logic              match;

  // Full 8-bit decode. A write to a different sel of the same rd is ignored.
  assign wr_count   = mtc0_we && (cp0_addr == ADDR_COUNT);
  assign wr_compare = mtc0_we && (cp0_addr == ADDR_COMPARE);

  // The tick comes from the registered phase. It is gated by count_dis so that
  // no increment is reported while frozen.
  assign tick = phase_p0 && !count_dis;

  // The match uses the registered Count. When Count is written and a match
  // occurs in the same cycle, the pre-write value is the one compared.
  assign match = (count_p0 == compare_data);

  // ---- stage p0: Count / phase state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p0 <= COUNT_INI;
      phase_p0 <= 1'b0;
    end else if (wr_count) begin
      // A software write wins over the increment and restarts the divider.
      // It also applies while frozen.
      count_p0 <= mtc0_data;
      phase_p0 <= 1'b0;
    end else if (!count_dis) begin
      phase_p0 <= ~phase_p0;
      if (tick) begin
        count_p0 <= count_inc(count_p0);
      end
    end
  end

  // ---- stage p0: timer interrupt ----
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_int_p0 <= 1'b0;
    end else if (wr_compare) begin
      // Clearing wins over a simultaneous match. If the new Compare equals
      // Count, the interrupt re-asserts on the following edge.
      timer_int_p0 <= 1'b0;
    end else if (match) begin
      timer_int_p0 <= 1'b1;
    end
  end

  assign cp0_Count_data = count_p0;
  assign timer_int      = timer_int_p0;
  assign count_tick     = tick;

endmodule

// File: tb/tb_cp0_count_timer.sv
// ---------------------------------------------------------------------------
// tb_cp0_count_timer
//
// Directed table of single-cycle vectors with hand-computed expected values.
// Hand-written sequences cover reset and the long freeze corner.
// Inputs change 1 ns after each rising edge. Outputs are sampled at that
// same point.
// ---------------------------------------------------------------------------
module tb_cp0_count_timer;

  localparam logic [7:0] AC = 8'b01001_000;
  localparam logic [7:0] AP = 8'b01011_000;

  logic        clk;
  logic        rst;
  logic        mtc0_we;
  logic [7:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic [31:0] compare_data;
  logic        count_dis;
  logic [31:0] cp0_Count_data;
  logic        timer_int;
  logic        count_tick;

  int checks;
  int errors;

  cp0_count_timer dut (
    .clk            (clk),
    .rst            (rst),
    .mtc0_we        (mtc0_we),
    .cp0_addr       (cp0_addr),
    .mtc0_data      (mtc0_data),
    .compare_data   (compare_data),
    .count_dis      (count_dis),
    .cp0_Count_data (cp0_Count_data),
    .timer_int      (timer_int),
    .count_tick     (count_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] cmp;
    logic        dis;
    logic [31:0] ecount;
    logic        eti;
    logic        etick;
  } vec_t;

  vec_t vecs[64];
  int   nvec;

  task automatic add(input logic we, input logic [7:0] addr, input logic [31:0] data,
                     input logic [31:0] cmp, input logic dis,
                     input logic [31:0] ecount, input logic eti, input logic etick);
    vecs[nvec].we     = we;
    vecs[nvec].addr   = addr;
    vecs[nvec].data   = data;
    vecs[nvec].cmp    = cmp;
    vecs[nvec].dis    = dis;
    vecs[nvec].ecount = ecount;
    vecs[nvec].eti    = eti;
    vecs[nvec].etick  = etick;
    nvec++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] ecount,
                       input logic eti, input logic etick);
    checks++;
    if (cp0_Count_data !== ecount || timer_int !== eti || count_tick !== etick) begin
      errors++;
      $display("FAIL %s: count=%h ti=%b tick=%b, expected count=%h ti=%b tick=%b",
               name, cp0_Count_data, timer_int, count_tick, ecount, eti, etick);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nvec   = 0;

    // Reset with a Count write pending and a matching Compare value. Reset must win.
    rst = 1'b1; mtc0_we = 1'b1; cp0_addr = AC; mtc0_data = 32'hDEAD_BEEF;
    compare_data = 32'h0; count_dis = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_hold%0d", i), 32'h0, 1'b0, 1'b0);
    end
    rst = 1'b0; mtc0_we = 1'b0; cp0_addr = 8'h00; mtc0_data = 32'h0;
    compare_data = 32'hFFFF_FFFF;
    #1;
    check("reset_release", 32'h0, 1'b0, 1'b0);

    // Cadence: Count = 1 after 2 edges, 5 after 10 edges. The tick alternates.
    for (int i = 1; i <= 10; i++)
      add(0, 8'h00, 0, 32'hFFFF_FFFF, 0, 32'(i / 2), 0, (i % 2) == 1);

    // Restart Count at 0 and set Compare to 3.
    add(1, AC, 32'h0, 32'hFFFF_FFFF, 0, 32'h0, 0, 0);
    add(0, 8'h00, 0, 3, 0, 0, 0, 1);
    add(0, 8'h00, 0, 3, 0, 1, 0, 0);
    add(0, 8'h00, 0, 3, 0, 1, 0, 1);
    add(0, 8'h00, 0, 3, 0, 2, 0, 0);
    add(0, 8'h00, 0, 3, 0, 2, 0, 1);
    add(0, 8'h00, 0, 3, 0, 3, 0, 0);   // Count reaches 3 at edge 6
    add(0, 8'h00, 0, 3, 0, 3, 1, 1);   // timer_int rises at edge 7
    add(0, 8'h00, 0, 3, 0, 4, 1, 0);
    add(0, 8'h00, 0, 3, 0, 4, 1, 1);   // sticky past Count = 4
    add(1, AP, 100, 3, 0, 5, 0, 0);    // Compare write clears
    add(0, 8'h00, 0, 100, 0, 5, 0, 1);

    // Clear and match in the same cycle: the clear wins, and the match sets on the next edge.
    add(1, AC, 3, 100, 0, 3, 0, 0);
    add(1, AP, 3, 3, 1, 3, 0, 0);
    add(0, 8'h00, 0, 3, 1, 3, 1, 0);

    // Count write with a new value equal to Compare is only compared from the next cycle.
    add(1, AP, 200, 3, 1, 3, 0, 0);
    add(1, AC, 32'h50, 32'h50, 1, 32'h50, 0, 0);
    add(0, 8'h00, 0, 32'h50, 1, 32'h50, 1, 0);
    // A Count write leaves timer_int set.
    add(1, AC, 32'h60, 32'h70, 1, 32'h60, 1, 0);
    // Writes to other addresses are ignored.
    add(1, 8'b01010_000, 0, 32'h70, 1, 32'h60, 1, 0);
    add(1, 8'b01011_001, 0, 32'h70, 1, 32'h60, 1, 0);
    add(1, 8'b01001_001, 0, 32'h70, 1, 32'h60, 1, 0);

    // Wrap from FFFF_FFFE through 0, with Compare = 0.
    add(1, AP, 0, 32'h70, 0, 32'h60, 0, 1);
    add(1, AC, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFE, 0, 0);
    add(0, 8'h00, 0, 0, 0, 32'hFFFF_FFFE, 0, 1);
    add(0, 8'h00, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
    add(0, 8'h00, 0, 0, 0, 32'hFFFF_FFFF, 0, 1);
    add(0, 8'h00, 0, 0, 0, 32'h0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 32'h0, 1, 1);
    // Freeze with the phase held at 1, and clear the interrupt.
    add(1, AP, 32'hFFFF_FFFF, 0, 1, 32'h0, 0, 0);

    for (int i = 0; i < nvec; i++) begin
      mtc0_we      = vecs[i].we;
      cp0_addr     = vecs[i].addr;
      mtc0_data    = vecs[i].data;
      compare_data = vecs[i].cmp;
      count_dis    = vecs[i].dis;
      step();
      check($sformatf("vec%0d", i), vecs[i].ecount, vecs[i].eti, vecs[i].etick);
    end

    // Long freeze: Count is constant and no tick is reported.
    mtc0_we = 1'b0; cp0_addr = 8'h00; mtc0_data = 32'h0;
    compare_data = 32'hFFFF_FFFF; count_dis = 1'b1;
    for (int i = 0; i < 19; i++) begin
      step();
      check($sformatf("freeze%0d", i), 32'h0, 1'b0, 1'b0);
    end
    // Release resumes from the held phase (1), so Count increments on the first edge.
    count_dis = 1'b0;
    #1;
    check("resume_tick", 32'h0, 1'b0, 1'b1);
    step();
    check("resume_inc", 32'h1, 1'b0, 1'b0);

    // A Count write during freeze is honoured immediately.
    count_dis = 1'b1;
    step();
    check("refreeze", 32'h1, 1'b0, 1'b1 & 1'b0);
    mtc0_we = 1'b1; cp0_addr = AC; mtc0_data = 32'h1234;
    step();
    check("frozen_write", 32'h1234, 1'b0, 1'b0);
    mtc0_we = 1'b0; cp0_addr = 8'h00; mtc0_data = 32'h0;
    step();
    check("frozen_hold", 32'h1234, 1'b0, 1'b0);
    count_dis = 1'b0;
    step();
    check("release1", 32'h1234, 1'b0, 1'b1);
    step();
    check("release2", 32'h1235, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
